// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared constants and types for the P6 hazard scoreboard.
//   - default register-address / Tuse-Tnew widths and MD latencies
//   - TUSE_NONE marks an operand that is not read
//   - Tnew codes for the common producer classes
//   - stage indices into the scoreboard (entry 0 = E)
//   - scoreboard entry layout for the default widths
package hazard_pkg;

    localparam int RAW_DEF      = 5;
    localparam int TW_DEF       = 2;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CW_DEF       = 4;

    // All-ones Tuse: the operand is never read, so it can never stall.
    localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

    // Tnew as seen when the instruction enters E.
    localparam logic [TW_DEF-1:0] TNEW_PC  = 2'd0;
    localparam logic [TW_DEF-1:0] TNEW_ALU = 2'd1;
    localparam logic [TW_DEF-1:0] TNEW_DM  = 2'd2;

    // Scoreboard entry indices; forward select for entry k is k+1.
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    typedef struct packed {
        logic                v;
        logic [RAW_DEF-1:0]  dst;
        logic [TW_DEF-1:0]   tnew;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage request and hazard response bundle.
//   master (decode side): drives d_* fields, receives stall / fwd selects / md_busy
//   slave  (scoreboard) : receives d_* fields, drives the responses
//   d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
//   d_md_start, d_md_div, d_md_use  -> scoreboard
//   stall, fwd_rs_sel, fwd_rt_sel, md_busy  <- scoreboard
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RAW    = RAW_DEF,
    parameter int TW     = TW_DEF
);

    localparam int SELW = $clog2(NSTAGE + 1);

    logic            d_valid;
    logic [RAW-1:0]  d_rs;
    logic [RAW-1:0]  d_rt;
    logic [TW-1:0]   d_tuse_rs;
    logic [TW-1:0]   d_tuse_rt;
    logic [RAW-1:0]  d_dst;
    logic [TW-1:0]   d_tnew;
    logic            d_md_start;
    logic            d_md_div;
    logic            d_md_use;

    logic            stall;
    logic [SELW-1:0] fwd_rs_sel;
    logic [SELW-1:0] fwd_rt_sel;
    logic            md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// md_busy_counter: tracks how long the mult/div unit stays busy.
//   clk, reset : clock and synchronous active-high reset
//   load       : an MD operation issues this cycle
//   load_div   : the issuing operation is a divide (longer latency)
//   busy       : counter non-zero; HI/LO users must wait
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    logic [CW-1:0] md_cnt;

    // A new issue reloads the full latency even if a previous op is still
    // counting down; otherwise count toward zero and hold there.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= load_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and forward-select generation.
//   clk, reset : clock and synchronous active-high reset
//   hz (slave) : D-stage operands/destination/Tuse/Tnew and MD flags in,
//                stall, fwd_rs_sel, fwd_rt_sel, md_busy out
// Every in-flight instruction past D occupies one scoreboard entry
// (0 = E, 1 = M, 2 = W, ...) holding {valid, dst, remaining Tnew}.
// Forward select k+1 means "take the value from entry k"; 0 = register file.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int RAW      = RAW_DEF,
    parameter int TW       = TW_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic clk,
    input  logic reset,
    hazard_scoreboard_if.slave hz
);

    localparam int SELW = $clog2(NSTAGE + 1);
    localparam logic [TW-1:0] TUSE_UNUSED = {TW{1'b1}};

    typedef struct packed {
        logic           v;
        logic [RAW-1:0] dst;
        logic [TW-1:0]  tnew;
    } entry_t;

    entry_t           sb_q    [NSTAGE];
    entry_t           sb_next [NSTAGE];
    logic [NSTAGE-1:0] match_rs;
    logic [NSTAGE-1:0] match_rt;

    logic            rs_hit, rt_hit;
    logic [TW-1:0]   rs_tnew, rt_tnew;
    logic [SELW-1:0] rs_sel, rt_sel;
    logic            stall_rs, stall_rt, stall_md;
    logic            stall_int;
    logic            md_busy_int;
    logic            md_issue;

    // Per-entry next state and operand matches. Entry 0 takes the D
    // instruction (or a bubble when stalling / empty); later entries shift
    // down with Tnew saturating at zero.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign sb_next[k].v    = hz.d_valid && !stall_int && (hz.d_dst != '0);
            assign sb_next[k].dst  = (hz.d_valid && !stall_int) ? hz.d_dst  : '0;
            assign sb_next[k].tnew = (hz.d_valid && !stall_int) ? hz.d_tnew : '0;
        end else begin : g_shift
            assign sb_next[k].v    = sb_q[k-1].v;
            assign sb_next[k].dst  = sb_q[k-1].dst;
            assign sb_next[k].tnew = (sb_q[k-1].tnew == '0) ? '0 : sb_q[k-1].tnew - 1'b1;
        end

        assign match_rs[k] = sb_q[k].v && (sb_q[k].dst == hz.d_rs) && (hz.d_rs != '0);
        assign match_rt[k] = sb_q[k].v && (sb_q[k].dst == hz.d_rt) && (hz.d_rt != '0);
    end

    // Scoreboard register; the oldest entry simply falls off the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= sb_next[k];
            end
        end
    end

    // Youngest-match priority: scan oldest to youngest so the lowest index
    // overwrites, shadowing stale writes of the same register further down.
    always_comb begin
        rs_hit  = 1'b0;
        rs_tnew = '0;
        rs_sel  = '0;
        rt_hit  = 1'b0;
        rt_tnew = '0;
        rt_sel  = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (match_rs[k]) begin
                rs_hit  = 1'b1;
                rs_tnew = sb_q[k].tnew;
                rs_sel  = SELW'(k + 1);
            end
            if (match_rt[k]) begin
                rt_hit  = 1'b1;
                rt_tnew = sb_q[k].tnew;
                rt_sel  = SELW'(k + 1);
            end
        end
    end

    // A producer whose value is not ready by the time the consumer needs it
    // forces a stall; a ready one (tnew 0) is forwarded from its entry.
    assign stall_rs  = rs_hit && (hz.d_tuse_rs != TUSE_UNUSED) && (rs_tnew > hz.d_tuse_rs);
    assign stall_rt  = rt_hit && (hz.d_tuse_rt != TUSE_UNUSED) && (rt_tnew > hz.d_tuse_rt);
    assign stall_md  = hz.d_md_use && md_busy_int;
    assign stall_int = hz.d_valid && (stall_rs || stall_rt || stall_md);

    assign md_issue = hz.d_valid && hz.d_md_start && !stall_int;

    md_busy_counter #(
        .CW       (CW),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_issue),
        .load_div (hz.d_md_div),
        .busy     (md_busy_int)
    );

    assign hz.stall      = stall_int;
    assign hz.fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_sel : '0;
    assign hz.fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_sel : '0;
    assign hz.md_busy    = md_busy_int;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed, table-driven bench for hazard_scoreboard
// (NSTAGE = 3, RAW = 5, TW = 2, MULT_CYC = 5, DIV_CYC = 10). Each table row
// is one D-stage cycle; stalled instructions are repeated in the next row.
// Multi-cycle MD stalls and reset-during-stall are hand-written sequences.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int N = 3;
    localparam int NONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_scoreboard_if #(.NSTAGE(N), .RAW(5), .TW(2)) hz ();

    hazard_scoreboard #(
        .NSTAGE(N), .RAW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10), .CW(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic [1:0] tuse_rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
        logic       md_use;
        logic       e_stall;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int valid, int rs, int tr, int rt, int tt, int dst, int tnew,
                                int es, int ers, int ert);
        vec_t v;
        v.valid    = 1'(valid);
        v.rs       = 5'(rs);
        v.tuse_rs  = 2'(tr);
        v.rt       = 5'(rt);
        v.tuse_rt  = 2'(tt);
        v.dst      = 5'(dst);
        v.tnew     = 2'(tnew);
        v.md_start = 1'b0;
        v.md_div   = 1'b0;
        v.md_use   = 1'b0;
        v.e_stall  = 1'(es);
        v.e_rs     = 2'(ers);
        v.e_rt     = 2'(ert);
        v.e_busy   = 1'b0;
        return v;
    endfunction

    function automatic vec_t withMd(vec_t base, int start, int dv, int use_md);
        vec_t v;
        v          = base;
        v.md_start = 1'(start);
        v.md_div   = 1'(dv);
        v.md_use   = 1'(use_md);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hz.d_valid    = v.valid;
        hz.d_rs       = v.rs;
        hz.d_tuse_rs  = v.tuse_rs;
        hz.d_rt       = v.rt;
        hz.d_tuse_rt  = v.tuse_rt;
        hz.d_dst      = v.dst;
        hz.d_tnew     = v.tnew;
        hz.d_md_start = v.md_start;
        hz.d_md_div   = v.md_div;
        hz.d_md_use   = v.md_use;
    endtask

    // Wait for the next active edge, then present a new D instruction.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
    endtask

    task automatic holdCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int tag,
                               input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, tag, actual, expected);
        end
    endtask

    task automatic checkRow(input vec_t v, input int tag);
        @(negedge clk);
        checkOutput("stall",      tag, 8'(hz.stall),      8'(v.e_stall));
        checkOutput("fwd_rs_sel", tag, 8'(hz.fwd_rs_sel), 8'(v.e_rs));
        checkOutput("fwd_rt_sel", tag, 8'(hz.fwd_rt_sel), 8'(v.e_rt));
        checkOutput("md_busy",    tag, 8'(hz.md_busy),    8'(v.e_busy));
    endtask

    // Hold an HI/LO reader in D and count how many cycles it is stalled.
    task automatic countMdStall(input string name, input int expected_cycles);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) holdCycle();
            @(negedge clk);
            if (hz.stall === 1'b1) begin
                n++;
                checkOutput({name, "_busy_during_stall"}, c, 8'(hz.md_busy), 8'd1);
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({name, "_stall_cycles"}, 0, 8'(n), 8'(expected_cycles));
        checkOutput({name, "_busy_after"}, 0, 8'(hz.md_busy), 8'd0);
    endtask

    initial begin
        vec_t nop, v;
        nop = mk(0, 0, NONE, 0, NONE, 0, 0, 0, 0, 0);

        // Directed pipeline trace; fwd expectations expressed as stage+1.
        tbl.push_back(mk(1, 2, 1, 0, NONE, 1, TNEW_DM, 0, 0, 0));          // lw $1
        tbl.push_back(mk(1, 1, 1, 5, 1, 3, TNEW_ALU, 1, 0, 0));            // addu rs=$1: stall
        tbl.push_back(mk(1, 1, 1, 5, 1, 3, TNEW_ALU, 0, 0, 0));            // released, $1 still tnew 1
        tbl.push_back(nop);
        tbl.push_back(nop);
        tbl.push_back(nop);
        tbl.push_back(mk(1, 2, 1, 0, NONE, 1, TNEW_DM, 0, 0, 0));          // lw $1
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0));                   // beq $1: stall
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0));                   // stall again
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, STG_W + 1, 0));           // forward from W
        tbl.push_back(mk(1, 6, 1, 7, 1, 4, TNEW_ALU, 0, 0, 0));            // addu $4
        tbl.push_back(mk(1, 8, 0, 4, 0, 0, 0, 1, 0, 0));                   // beq rt=$4: stall
        tbl.push_back(mk(1, 8, 0, 4, 0, 0, 0, 0, 0, STG_M + 1));           // forward from M
        tbl.push_back(mk(1, 0, NONE, 0, NONE, 31, TNEW_PC, 0, 0, 0));      // jal
        tbl.push_back(mk(1, 31, 0, 0, NONE, 0, 0, 0, STG_E + 1, 0));       // jr $31
        tbl.push_back(mk(1, 3, 1, 0, NONE, 2, TNEW_DM, 0, 0, 0));          // lw $2
        tbl.push_back(mk(1, 5, 1, 2, NONE, 2, TNEW_ALU, 0, 0, 0));         // ori $2 (rt unused)
        tbl.push_back(nop);
        tbl.push_back(mk(1, 2, 1, 0, 1, 9, TNEW_ALU, 0, STG_M + 1, 0));    // youngest ($2 from ori)
        tbl.push_back(mk(1, 3, 1, 0, NONE, 0, TNEW_DM, 0, 0, 0));          // load to $0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));                   // beq $0,$0
        tbl.push_back(mk(1, 0, NONE, 0, NONE, 10, TNEW_ALU, 0, 0, 0));     // addu $10
        tbl.push_back(mk(0, 10, 0, 0, NONE, 0, 0, 0, 0, 0));               // invalid D never stalls
        tbl.push_back(mk(1, 10, 0, 10, 1, 0, 0, 0, STG_M + 1, STG_M + 1)); // both operands forward
        tbl.push_back(mk(1, 3, 1, 0, NONE, 11, TNEW_DM, 0, 0, 0));         // lw $11
        tbl.push_back(mk(1, 11, 1, 11, 1, 12, TNEW_ALU, 1, 0, 0));         // rs+rt hazard: one stall
        tbl.push_back(mk(1, 11, 1, 11, 1, 12, TNEW_ALU, 0, 0, 0));

        drive(nop);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        v = nop;
        checkRow(v, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkRow(tbl[i], i);
        end

        // mult then mflo: five stall cycles
        for (int i = 0; i < 3; i++) applyStimulus(nop);
        v = withMd(mk(1, 0, NONE, 0, NONE, 0, 0, 0, 0, 0), 1, 0, 1);
        applyStimulus(v);
        checkRow(v, 100);
        applyStimulus(withMd(mk(1, 0, NONE, 0, NONE, 8, TNEW_ALU, 0, 0, 0), 0, 0, 1));
        countMdStall("mult_mflo", 5);

        // div then mfhi: ten stall cycles
        v = withMd(mk(1, 0, NONE, 0, NONE, 0, 0, 0, 0, 0), 1, 1, 1);
        applyStimulus(v);
        checkRow(v, 101);
        applyStimulus(withMd(mk(1, 0, NONE, 0, NONE, 9, TNEW_ALU, 0, 0, 0), 0, 0, 1));
        countMdStall("div_mfhi", 10);

        // mult then an ordinary ALU op: busy but no stall
        v = withMd(mk(1, 0, NONE, 0, NONE, 0, 0, 0, 0, 0), 1, 0, 1);
        applyStimulus(v);
        checkRow(v, 102);
        v = mk(1, 0, NONE, 0, NONE, 13, TNEW_ALU, 0, 0, 0);
        v.e_busy = 1'b1;
        applyStimulus(v);
        checkRow(v, 103);
        for (int i = 0; i < 6; i++) applyStimulus(nop);
        checkRow(nop, 104);

        // Reset in the middle of a div busy window and a lw stall
        v = withMd(mk(1, 0, NONE, 0, NONE, 0, 0, 0, 0, 0), 1, 1, 1);
        applyStimulus(v);
        checkRow(v, 110);
        v = mk(1, 2, 1, 0, NONE, 1, TNEW_DM, 0, 0, 0);
        v.e_busy = 1'b1;
        applyStimulus(v);
        checkRow(v, 111);
        v = withMd(mk(1, 1, 1, 0, NONE, 5, TNEW_ALU, 1, 0, 0), 0, 0, 1);
        v.e_busy = 1'b1;
        applyStimulus(v);
        reset = 1'b1;
        checkRow(v, 112);
        holdCycle();
        reset = 1'b0;
        v.e_stall = 1'b0;
        v.e_busy  = 1'b0;
        checkRow(v, 113);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
